// File: rtl/alu_issue.sv
// Issue stage in front of the 64-bit ALU: decodes RV64 ALU instructions into
// alucontrol/operands and holds them in a 2-entry skid buffer toward execute.
`ifndef ALU_ADD
`define ALU_ADD 4'b0010
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'b0110
`endif
`ifndef ALU_AND
`define ALU_AND 4'b0000
`endif
`ifndef ALU_OR
`define ALU_OR  4'b0001
`endif

module alu_issue (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [63:0] pc,
   input  logic [63:0] rs1_data,
   input  logic [63:0] rs2_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  alucontrol,
   output logic [63:0] op_a,
   output logic [63:0] op_b,
   output logic [4:0]  rd,
   output logic        reg_write,
   output logic        illegal
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   function automatic logic signed [63:0] sext12(input logic [11:0] v);
      sext12 = {{52{v[11]}}, v};
   endfunction

   function automatic logic signed [63:0] sext_upper(input logic [19:0] v);
      sext_upper = {{32{v[19]}}, v, 12'b0};
   endfunction

   logic [6:0]         opcode;
   logic [2:0]         funct3;
   logic [6:0]         funct7;
   logic signed [63:0] imm_i;
   logic signed [63:0] imm_u;

   logic [3:0]         dec_ctl_p0;
   logic [63:0]        dec_a_p0;
   logic [63:0]        dec_b_p0;
   logic               dec_legal_p0;
   logic               dec_wr_p0;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign imm_i  = sext12(instr[31:20]);
   assign imm_u  = sext_upper(instr[31:12]);

   // Decode stage: operands stay zero unless the encoding is fully recognised
   always_comb begin
      dec_ctl_p0   = `ALU_ADD;
      dec_a_p0     = '0;
      dec_b_p0     = '0;
      dec_legal_p0 = 1'b0;
      case (opcode)
         7'b0110011: begin
            if (funct7 == 7'b0000000) begin
               case (funct3)
                  3'b000:  begin dec_ctl_p0 = `ALU_ADD; dec_legal_p0 = 1'b1; end
                  3'b111:  begin dec_ctl_p0 = `ALU_AND; dec_legal_p0 = 1'b1; end
                  3'b110:  begin dec_ctl_p0 = `ALU_OR;  dec_legal_p0 = 1'b1; end
                  default: dec_legal_p0 = 1'b0;
               endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               dec_ctl_p0   = `ALU_SUB;
               dec_legal_p0 = 1'b1;
            end
            if (dec_legal_p0) begin
               dec_a_p0 = rs1_data;
               dec_b_p0 = rs2_data;
            end
         end
         7'b0010011: begin
            case (funct3)
               3'b000:  begin dec_ctl_p0 = `ALU_ADD; dec_legal_p0 = 1'b1; end
               3'b111:  begin dec_ctl_p0 = `ALU_AND; dec_legal_p0 = 1'b1; end
               3'b110:  begin dec_ctl_p0 = `ALU_OR;  dec_legal_p0 = 1'b1; end
               default: dec_legal_p0 = 1'b0;
            endcase
            if (dec_legal_p0) begin
               dec_a_p0 = rs1_data;
               dec_b_p0 = imm_i;
            end
         end
         7'b0110111: begin
            dec_legal_p0 = 1'b1;
            dec_b_p0     = imm_u;
         end
         7'b0010111: begin
            dec_legal_p0 = 1'b1;
            dec_a_p0     = pc;
            dec_b_p0     = imm_u;
         end
         default: dec_legal_p0 = 1'b0;
      endcase
      dec_wr_p0 = dec_legal_p0 && (instr[11:7] != 5'd0);
   end

   state_t      state_p1;
   logic [3:0]  skid_ctl_p1;
   logic [63:0] skid_a_p1;
   logic [63:0] skid_b_p1;
   logic [4:0]  skid_rd_p1;
   logic        skid_wr_p1;
   logic        skid_ill_p1;
   logic        accept;
   logic        pop;

   assign accept = in_valid && in_ready;
   assign pop    = out_valid && out_ready;

   // Storage stage: head registers are the outputs, skid holds the younger entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_p1    <= EMPTY;
         out_valid   <= 1'b0;
         in_ready    <= 1'b1;
         alucontrol  <= `ALU_ADD;
         op_a        <= '0;
         op_b        <= '0;
         rd          <= '0;
         reg_write   <= 1'b0;
         illegal     <= 1'b0;
         skid_ctl_p1 <= `ALU_ADD;
         skid_a_p1   <= '0;
         skid_b_p1   <= '0;
         skid_rd_p1  <= '0;
         skid_wr_p1  <= 1'b0;
         skid_ill_p1 <= 1'b0;
      end else if (flush) begin
         state_p1  <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state_p1)
            EMPTY: begin
               if (accept) begin
                  alucontrol <= dec_ctl_p0;
                  op_a       <= dec_a_p0;
                  op_b       <= dec_b_p0;
                  rd         <= instr[11:7];
                  reg_write  <= dec_wr_p0;
                  illegal    <= !dec_legal_p0;
                  state_p1   <= ONE;
                  out_valid  <= 1'b1;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  alucontrol <= dec_ctl_p0;
                  op_a       <= dec_a_p0;
                  op_b       <= dec_b_p0;
                  rd         <= instr[11:7];
                  reg_write  <= dec_wr_p0;
                  illegal    <= !dec_legal_p0;
               end else if (accept) begin
                  skid_ctl_p1 <= dec_ctl_p0;
                  skid_a_p1   <= dec_a_p0;
                  skid_b_p1   <= dec_b_p0;
                  skid_rd_p1  <= instr[11:7];
                  skid_wr_p1  <= dec_wr_p0;
                  skid_ill_p1 <= !dec_legal_p0;
                  state_p1    <= FULL;
                  in_ready    <= 1'b0;
               end else if (pop) begin
                  state_p1  <= EMPTY;
                  out_valid <= 1'b0;
               end
            end
            FULL: begin
               if (pop) begin
                  alucontrol <= skid_ctl_p1;
                  op_a       <= skid_a_p1;
                  op_b       <= skid_b_p1;
                  rd         <= skid_rd_p1;
                  reg_write  <= skid_wr_p1;
                  illegal    <= skid_ill_p1;
                  state_p1   <= ONE;
                  in_ready   <= 1'b1;
               end
            end
            default: begin
               state_p1  <= EMPTY;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed instructions push expected entries,
// a negedge monitor pops and compares whenever execute consumes the head.
`ifndef ALU_ADD
`define ALU_ADD 4'b0010
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'b0110
`endif
`ifndef ALU_AND
`define ALU_AND 4'b0000
`endif
`ifndef ALU_OR
`define ALU_OR  4'b0001
`endif

module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [63:0] pc;
   logic [63:0] rs1_data;
   logic [63:0] rs2_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  alucontrol;
   logic [63:0] op_a;
   logic [63:0] op_b;
   logic [4:0]  rd;
   logic        reg_write;
   logic        illegal;

   typedef struct packed {
      logic [3:0]  ctl;
      logic [63:0] a;
      logic [63:0] b;
      logic [4:0]  rd;
      logic        wr;
      logic        ill;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alu_issue dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .alucontrol(alucontrol), .op_a(op_a), .op_b(op_b), .rd(rd),
      .reg_write(reg_write), .illegal(illegal)
   );

   function automatic exp_t mk(input logic [3:0] c, input logic [63:0] a,
                               input logic [63:0] b, input logic [4:0] r,
                               input logic w, input logic il);
      exp_t e;
      e.ctl = c; e.a = a; e.b = b; e.rd = r; e.wr = w; e.ill = il;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_entry: got op_a %h expected no entry", op_a);
         end else begin
            e = q.pop_front();
            chk("alucontrol", 64'(alucontrol), 64'(e.ctl));
            chk("op_a", op_a, e.a);
            chk("op_b", op_b, e.b);
            chk("rd", 64'(rd), 64'(e.rd));
            chk("reg_write", 64'(reg_write), 64'(e.wr));
            chk("illegal", 64'(illegal), 64'(e.ill));
         end
      end
   end

   task automatic send(input logic [31:0] i, input logic [63:0] p, input logic [63:0] r1,
                       input logic [63:0] r2, input exp_t e);
      instr = i; pc = p; rs1_data = r1; rs2_data = r2; in_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 20 cycles");
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 20; n++) begin
         if (q.size() == 0) return;
         @(posedge clk); #1;
      end
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      chk({tag, "_alucontrol"}, 64'(alucontrol), 64'(`ALU_ADD));
      chk({tag, "_op_a"}, op_a, 64'd0);
      chk({tag, "_op_b"}, op_b, 64'd0);
      chk({tag, "_rd"}, 64'(rd), 64'd0);
      chk({tag, "_reg_write"}, 64'(reg_write), 64'd0);
      chk({tag, "_illegal"}, 64'(illegal), 64'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
      #12;
      chk_reset_outputs("reset");
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Decode coverage with execute always ready: one instruction per cycle
      send(32'h002081B3, 64'h0, 64'd5, 64'd7, mk(`ALU_ADD, 64'd5, 64'd7, 5'd3, 1'b1, 1'b0));
      chk("latency_out_valid", 64'(out_valid), 64'd1);
      send(32'h402081B3, 64'h0, 64'd5, 64'd7, mk(`ALU_SUB, 64'd5, 64'd7, 5'd3, 1'b1, 1'b0));
      send(32'hFFF00093, 64'h0, 64'd0, 64'd99, mk(`ALU_ADD, 64'd0, 64'hFFFFFFFFFFFFFFFF, 5'd1, 1'b1, 1'b0));
      send(32'h800002B7, 64'h0, 64'hAA, 64'hBB, mk(`ALU_ADD, 64'd0, 64'hFFFFFFFF80000000, 5'd5, 1'b1, 1'b0));
      send(32'h00001297, 64'h1000, 64'hAA, 64'hBB, mk(`ALU_ADD, 64'h1000, 64'h1000, 5'd5, 1'b1, 1'b0));
      send(32'h0020F1B3, 64'h0, 64'hF0F0, 64'hFF00, mk(`ALU_AND, 64'hF0F0, 64'hFF00, 5'd3, 1'b1, 1'b0));
      send(32'h0020E1B3, 64'h0, 64'hF0F0, 64'hFF00, mk(`ALU_OR, 64'hF0F0, 64'hFF00, 5'd3, 1'b1, 1'b0));
      send(32'h0F017093, 64'h0, 64'h1234, 64'd5, mk(`ALU_AND, 64'h1234, 64'hF0, 5'd1, 1'b1, 1'b0));
      send(32'h002091B3, 64'h0, 64'd5, 64'd7, mk(`ALU_ADD, 64'd0, 64'd0, 5'd3, 1'b0, 1'b1));
      send(32'h4020F1B3, 64'h0, 64'd5, 64'd7, mk(`ALU_ADD, 64'd0, 64'd0, 5'd3, 1'b0, 1'b1));
      send(32'h00109093, 64'h0, 64'd5, 64'd7, mk(`ALU_ADD, 64'd0, 64'd0, 5'd1, 1'b0, 1'b1));
      send(32'h0000006F, 64'h40, 64'd5, 64'd7, mk(`ALU_ADD, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1));
      send(32'h00208033, 64'h0, 64'd5, 64'd7, mk(`ALU_ADD, 64'd5, 64'd7, 5'd0, 1'b0, 1'b0));
      drain();

      // Backpressure: fill both entries, third offer must stall
      out_ready = 1'b0;
      send(32'h002081B3, 64'h0, 64'd11, 64'd22, mk(`ALU_ADD, 64'd11, 64'd22, 5'd3, 1'b1, 1'b0));
      send(32'h402081B3, 64'h0, 64'd33, 64'd44, mk(`ALU_SUB, 64'd33, 64'd44, 5'd3, 1'b1, 1'b0));
      instr = 32'h0020E1B3; rs1_data = 64'd55; rs2_data = 64'd66; in_valid = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("full_in_ready", 64'(in_ready), 64'd0);
         chk("hold_out_valid", 64'(out_valid), 64'd1);
         chk("hold_alucontrol", 64'(alucontrol), 64'(`ALU_ADD));
         chk("hold_op_a", op_a, 64'd11);
         chk("hold_op_b", op_b, 64'd22);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      send(32'h0020E1B3, 64'h0, 64'd55, 64'd66, mk(`ALU_OR, 64'd55, 64'd66, 5'd3, 1'b1, 1'b0));
      drain();
      @(negedge clk);
      chk("drained_in_ready", 64'(in_ready), 64'd1);
      chk("drained_out_valid", 64'(out_valid), 64'd0);

      // Flush while FULL with an offer pending
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(32'h002081B3, 64'h0, 64'd1, 64'd2, mk(`ALU_ADD, 64'd1, 64'd2, 5'd3, 1'b1, 1'b0));
      send(32'h002081B3, 64'h0, 64'd3, 64'd4, mk(`ALU_ADD, 64'd3, 64'd4, 5'd3, 1'b1, 1'b0));
      instr = 32'h002081B3; rs1_data = 64'd9; rs2_data = 64'd9; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      q.delete();
      chk("flush_full_out_valid", 64'(out_valid), 64'd0);
      chk("flush_full_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      chk("flush_full_stays_empty", 64'(out_valid), 64'd0);

      // Flush while ONE with an accept in the same cycle: accept dropped
      @(posedge clk); #1;
      send(32'h002081B3, 64'h0, 64'd6, 64'd6, mk(`ALU_ADD, 64'd6, 64'd6, 5'd3, 1'b1, 1'b0));
      instr = 32'h402081B3; rs1_data = 64'd8; rs2_data = 64'd8; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      q.delete();
      chk("flush_one_out_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("flush_one_dropped", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(32'h0020F1B3, 64'h0, 64'h77, 64'h0F, mk(`ALU_AND, 64'h77, 64'h0F, 5'd3, 1'b1, 1'b0));
      drain();

      // Asynchronous reset mid-stream, away from any clock edge
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(32'h002081B3, 64'h0, 64'h123, 64'h456, mk(`ALU_ADD, 64'h123, 64'h456, 5'd3, 1'b1, 1'b0));
      send(32'hFFF00093, 64'h0, 64'h789, 64'h0, mk(`ALU_ADD, 64'h789, 64'hFFFFFFFFFFFFFFFF, 5'd1, 1'b1, 1'b0));
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs("midreset");
      q.delete();
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(32'h00001297, 64'h2000, 64'h0, 64'h0, mk(`ALU_ADD, 64'h2000, 64'h1000, 5'd5, 1'b1, 1'b0));
      drain();
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
